aes_inv_key_sched: RTL
======================

AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

Interface
REQ-001 The block SHALL have no parameters; key size is AES-128 (Nr = 10), fixed.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a sequence; sampled only in IDLE.
REQ-005 key_in  input  128  round-10 key (w40..w43, w40 in bits 127:96); sampled with start.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 rk_valid  output  1  rk_out/rk_round hold a valid round key.
REQ-008 rk_ready  input  1  consumer accepts the current round key.
REQ-009 rk_out  output  128  current round key, word 0 in bits 127:96.
REQ-010 rk_round  output  4  round index of rk_out, 10 down to 0.
REQ-011 done  output  1  single-cycle pulse on acceptance of the round-0 key.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-013 In IDLE with start=1, the block SHALL load key_in, set rk_round=10 and enter RUN; rk_valid SHALL be high in the next cycle (latency 1).
REQ-014 start SHALL be ignored while in RUN; key_in SHALL be ignored except in the start cycle.
REQ-015 In RUN, rk_valid SHALL be 1; a transfer SHALL occur only when rk_valid and rk_ready are both 1.
REQ-016 While rk_valid=1 and rk_ready=0, rk_out and rk_round SHALL remain stable.
REQ-017 On transfer with rk_round>0, the next key SHALL be (k0,k1,k2,k3) -> (p0,p1,p2,p3): p3=k3^k2, p2=k2^k1, p1=k1^k0, p0=k0^SubWord(RotWord(p3))^Rcon(rk_round), and rk_round SHALL decrement by 1, all in one cycle.
REQ-018 RotWord SHALL rotate bytes left by one (b0b1b2b3 -> b1b2b3b0); SubWord SHALL apply the AES forward S-box to each byte.
REQ-019 Rcon(r) SHALL be {rc,24'h0} with rc = 01,02,04,08,10,20,40,80,1b,36 for r=1..10; Rcon(0)=0 (unused).
REQ-020 On transfer with rk_round=0, the block SHALL pulse done for one cycle, deassert rk_valid and return to IDLE in the same edge.
REQ-021 A start asserted in the cycle done pulses SHALL be ignored (FSM still in RUN); start in the following cycle SHALL be accepted.
REQ-022 Exactly 11 transfers SHALL occur per sequence, rounds 10,9,...,0, with rk_ready held high giving one key per cycle.
REQ-023 In IDLE, rk_out and rk_round SHALL retain their last values; rk_valid SHALL be 0.

Reset
REQ-024 On rst_n=0, asynchronously: state=IDLE, rk_valid=0, done=0, busy=0, rk_out=0, rk_round=0.
REQ-025 Reset asserted mid-sequence SHALL abort it with no done pulse; after release, the block SHALL wait for a new start.

Structure
REQ-026 A shared package aes_pkg SHALL hold the FSM state type, AES-128 width constants (128-bit key, 32-bit word, Nr=10) and the Rcon lookup function.
REQ-027 The byte S-box SHALL be a sub-module aes_sbox (8-bit in, 8-bit out, combinational), instantiated four times for SubWord.
REQ-028 The key register, round counter and FSM SHALL reside in aes_inv_key_sched; no other memories.

Verification
REQ-029 FIPS-197 vector: start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1 -> rk_round 10..0 on consecutive cycles, round 9 = ac7766f319fadc2128d12941575c006e, round 0 = 2b7e151628aed2a6abf7158809cf4f3c, done with round 0.
REQ-030 Backpressure: same vector, rk_ready random 50% -> identical 11-key sequence, outputs stable during stalls, done only once.
REQ-031 start pulsed during RUN with different key_in -> sequence unaffected.
REQ-032 Reset asserted after round 6 accepted -> rk_valid=0, busy=0 immediately, no done; new start then yields correct full sequence.
REQ-033 Back-to-back: start on cycle after done with key_in=round-10 key of all-zero cipher key (b4ef5bcb3e92e21123e951cf6f8f188e) -> round 0 = all zeros.

Source files
------------

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-128 inverse key schedule:
//   - state_e : FSM state type of the key-schedule walker (IDLE / RUN)
//   - width constants for key, word and byte, plus round count NR
//   - rcon()  : round-constant lookup indexed by round number
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int KEY_W  = 128;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int NR     = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Round constant byte for rounds 1..10; round 0 never consumes one.
  function automatic logic [BYTE_W-1:0] rcon(input logic [3:0] round);
    logic [BYTE_W-1:0] rc;
    rc = 8'h00;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box for a single byte.
// Ports:
//   in_byte  : byte to substitute
//   out_byte : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] in_byte,
  output logic [BYTE_W-1:0] out_byte
);

  localparam logic [BYTE_W-1:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_inv_key_sched.sv
// ---------------------------------------------------------------------------
// aes_inv_key_sched
// Walks the AES-128 key schedule backwards: starting from the round-10 key it
// emits the round keys 10, 9, ..., 0 over a valid/ready handshake, deriving
// each earlier key from the current one in a single cycle.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   start      : begin a sequence (honoured only while idle)
//   key_in     : round-10 key, word w40 in bits 127:96, sampled with start
//   busy       : high while a sequence is in progress
//   rk_valid   : rk_out / rk_round hold a round key for the consumer
//   rk_ready   : consumer accepts the current round key
//   rk_out     : current round key, word 0 in bits 127:96
//   rk_round   : round index of rk_out (10 down to 0)
//   done       : high in the cycle the round-0 key is accepted
// ---------------------------------------------------------------------------
module aes_inv_key_sched
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KEY_W-1:0]  key_in,
  output logic              busy,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [KEY_W-1:0]  rk_out,
  output logic [3:0]        rk_round,
  output logic              done
);

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [3:0]         round_q, round_d;

  logic [WORD_W-1:0]  k0, k1, k2, k3;
  logic [WORD_W-1:0]  p0, p1, p2, p3;
  logic [WORD_W-1:0]  rot_word, sub_word;
  logic [KEY_W-1:0]   prev_key;

  // Inverse step of the schedule. Words 1..3 of the earlier key fall out of
  // plain XORs of neighbours; word 0 needs the g() function applied to the
  // freshly recovered word 3, exactly as the forward expansion used it.
  always_comb begin
    k0 = key_q[127:96];
    k1 = key_q[95:64];
    k2 = key_q[63:32];
    k3 = key_q[31:0];
    p3 = k3 ^ k2;
    p2 = k2 ^ k1;
    p1 = k1 ^ k0;
    rot_word = {p3[23:0], p3[31:24]};
    p0 = k0 ^ sub_word ^ {rcon(round_q), 24'h0};
    prev_key = {p0, p1, p2, p3};
  end

  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox u_sbox (
      .in_byte  (rot_word[BYTE_W*i +: BYTE_W]),
      .out_byte (sub_word[BYTE_W*i +: BYTE_W])
    );
  end

  // Next-state and output logic. done is combinational so it coincides with
  // the round-0 transfer while the FSM is still in RUN; a start seen in that
  // cycle is therefore ignored and the next cycle's start is honoured.
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    round_d  = round_q;
    busy     = 1'b0;
    rk_valid = 1'b0;
    done     = 1'b0;
    rk_out   = key_q;
    rk_round = round_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = 4'(NR);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        rk_valid = 1'b1;
        if (rk_ready) begin
          if (round_q == 4'd0) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            key_d   = prev_key;
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, key and round registers; reset clears everything so a sequence
  // interrupted by reset leaves no stale handshake behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

endmodule
